// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - RV32I integer execute unit with ROB-tagged result broadcast
// Optional ALU_PIPE2_EN: registers compare/shift results before the target/result mux (2-cycle latency).

`ifndef OP_WID
`define OP_WID 7
`endif
`ifndef FUNCT3_WID
`define FUNCT3_WID 3
`endif
`ifndef ROB_POS_WID
`define ROB_POS_WID 4
`endif

module alu_exec (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    rollback,
    input  logic                    alu_en,
    input  logic [31:0]             alu_val1,
    input  logic [31:0]             alu_val2,
    input  logic [31:0]             alu_imm,
    input  logic [31:0]             alu_pc,
    input  logic [`OP_WID-1:0]      alu_opcode,
    input  logic [`FUNCT3_WID-1:0]  alu_funct3,
    input  logic                    alu_funct7,
    input  logic [`ROB_POS_WID-1:0] alu_rob_pos,
    output logic                    alu_result,
    output logic [31:0]             alu_result_val,
    output logic [`ROB_POS_WID-1:0] alu_result_rob_pos,
    output logic                    alu_result_jump,
    output logic [31:0]             alu_result_pc
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] K_LUI   = 3'd0;
    localparam logic [2:0] K_AUIPC = 3'd1;
    localparam logic [2:0] K_JAL   = 3'd2;
    localparam logic [2:0] K_JALR  = 3'd3;
    localparam logic [2:0] K_BR    = 3'd4;
    localparam logic [2:0] K_ALU   = 3'd5;
    localparam logic [2:0] K_BAD   = 3'd6;

    typedef struct packed {
        logic [2:0]              kind;
        logic                    cond;
        logic [31:0]             alu_val;
        logic [31:0]             pc;
        logic [31:0]             imm;
        logic [31:0]             val1;
        logic [`ROB_POS_WID-1:0] rob_pos;
    } s1_t;

    logic        capture;
    logic [31:0] op2;
    logic [4:0]  shamt;
    logic        lt_s;
    logic        lt_u;
    logic        eq;
    s1_t         s1_c;

    assign capture = alu_en && rdy && !rollback;

    // Branches and register-register ops share the comparators on val2.
    always_comb begin
        op2   = ((alu_opcode == OPC_OP) || (alu_opcode == OPC_BRANCH)) ? alu_val2 : alu_imm;
        shamt = op2[4:0];
        lt_s  = $signed(alu_val1) < $signed(op2);
        lt_u  = alu_val1 < op2;
        eq    = alu_val1 == op2;

        s1_c         = '0;
        s1_c.pc      = alu_pc;
        s1_c.imm     = alu_imm;
        s1_c.val1    = alu_val1;
        s1_c.rob_pos = alu_rob_pos;
        s1_c.kind    = K_BAD;

        case (alu_opcode)
            OPC_LUI:   s1_c.kind = K_LUI;
            OPC_AUIPC: s1_c.kind = K_AUIPC;
            OPC_JAL:   s1_c.kind = K_JAL;
            OPC_JALR:  s1_c.kind = K_JALR;
            OPC_BRANCH: begin
                s1_c.kind = K_BR;
                case (alu_funct3)
                    3'b000:  s1_c.cond = eq;
                    3'b001:  s1_c.cond = !eq;
                    3'b100:  s1_c.cond = lt_s;
                    3'b101:  s1_c.cond = !lt_s;
                    3'b110:  s1_c.cond = lt_u;
                    3'b111:  s1_c.cond = !lt_u;
                    default: s1_c.kind = K_BAD;
                endcase
            end
            OPC_OPIMM, OPC_OP: begin
                s1_c.kind = K_ALU;
                case (alu_funct3)
                    3'b000: s1_c.alu_val = (alu_opcode == OPC_OP && alu_funct7) ?
                                           alu_val1 - op2 : alu_val1 + op2;
                    3'b001: s1_c.alu_val = alu_val1 << shamt;
                    3'b010: s1_c.alu_val = {31'd0, lt_s};
                    3'b011: s1_c.alu_val = {31'd0, lt_u};
                    3'b100: s1_c.alu_val = alu_val1 ^ op2;
                    3'b101: s1_c.alu_val = alu_funct7 ?
                                           32'($signed(alu_val1) >>> shamt) : alu_val1 >> shamt;
                    3'b110: s1_c.alu_val = alu_val1 | op2;
                    default: s1_c.alu_val = alu_val1 & op2;
                endcase
            end
            default: s1_c.kind = K_BAD;
        endcase
    end

    logic st2_valid;
    s1_t  st2;

`ifdef ALU_PIPE2_EN
    s1_t  s1_q;
    s1_t  s1_d;
    logic s1_valid_q;
    logic s1_valid_d;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        if (rdy) begin
            s1_valid_d = capture;
            if (capture) begin
                s1_d = s1_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
        end
    end

    assign st2_valid = s1_valid_q;
    assign st2       = s1_q;
`else
    assign st2_valid = capture;
    assign st2       = s1_c;
`endif

    logic [31:0] pc_plus4;
    logic [31:0] pc_plus_imm;
    logic [31:0] fin_val;
    logic        fin_jump;
    logic [31:0] fin_pc;

    always_comb begin
        pc_plus4    = st2.pc + 32'd4;
        pc_plus_imm = st2.pc + st2.imm;
        fin_val     = 32'd0;
        fin_jump    = 1'b0;
        fin_pc      = pc_plus4;
        case (st2.kind)
            K_LUI:   fin_val = st2.imm;
            K_AUIPC: fin_val = pc_plus_imm;
            K_JAL: begin
                fin_val  = pc_plus4;
                fin_jump = 1'b1;
                fin_pc   = pc_plus_imm;
            end
            K_JALR: begin
                fin_val  = pc_plus4;
                fin_jump = 1'b1;
                fin_pc   = (st2.val1 + st2.imm) & ~32'd1;
            end
            K_BR: begin
                fin_jump = st2.cond;
                fin_pc   = st2.cond ? pc_plus_imm : pc_plus4;
            end
            K_ALU:   fin_val = st2.alu_val;
            default: fin_val = 32'd0;
        endcase
    end

    logic                    res_valid_q, res_valid_d;
    logic [31:0]             res_val_q, res_val_d;
    logic [`ROB_POS_WID-1:0] res_rob_q, res_rob_d;
    logic                    res_jump_q, res_jump_d;
    logic [31:0]             res_pc_q, res_pc_d;

    // A stalled broadcast stays visible; it drops on the first enabled edge.
    always_comb begin
        res_valid_d = res_valid_q;
        res_val_d   = res_val_q;
        res_rob_d   = res_rob_q;
        res_jump_d  = res_jump_q;
        res_pc_d    = res_pc_q;
        if (rdy) begin
            res_valid_d = st2_valid && !rollback;
            if (st2_valid) begin
                res_val_d  = fin_val;
                res_rob_d  = st2.rob_pos;
                res_jump_d = fin_jump;
                res_pc_d   = fin_pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_q <= 1'b0;
            res_val_q   <= 32'd0;
            res_rob_q   <= '0;
            res_jump_q  <= 1'b0;
            res_pc_q    <= 32'd0;
        end else begin
            res_valid_q <= res_valid_d;
            res_val_q   <= res_val_d;
            res_rob_q   <= res_rob_d;
            res_jump_q  <= res_jump_d;
            res_pc_q    <= res_pc_d;
        end
    end

    assign alu_result         = res_valid_q;
    assign alu_result_val     = res_val_q;
    assign alu_result_rob_pos = res_rob_q;
    assign alu_result_jump    = res_jump_q;
    assign alu_result_pc      = res_pc_q;

endmodule

// File: tb/tb_alu_exec.sv
// tb/tb_alu_exec.sv - randomized bench for alu_exec against an ROB-side scoreboard model
// Honours ALU_PIPE2_EN for the expected latency.

`ifndef OP_WID
`define OP_WID 7
`endif
`ifndef FUNCT3_WID
`define FUNCT3_WID 3
`endif
`ifndef ROB_POS_WID
`define ROB_POS_WID 4
`endif

module tb_alu_exec;

`ifdef ALU_PIPE2_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic                    clk = 1'b0;
    logic                    rst, rdy, rollback, alu_en;
    logic [31:0]             alu_val1, alu_val2, alu_imm, alu_pc;
    logic [`OP_WID-1:0]      alu_opcode;
    logic [`FUNCT3_WID-1:0]  alu_funct3;
    logic                    alu_funct7;
    logic [`ROB_POS_WID-1:0] alu_rob_pos;
    logic                    alu_result;
    logic [31:0]             alu_result_val;
    logic [`ROB_POS_WID-1:0] alu_result_rob_pos;
    logic                    alu_result_jump;
    logic [31:0]             alu_result_pc;

    always #5 clk = ~clk;

    alu_exec dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .alu_en(alu_en),
        .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_imm(alu_imm), .alu_pc(alu_pc),
        .alu_opcode(alu_opcode), .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
        .alu_rob_pos(alu_rob_pos), .alu_result(alu_result), .alu_result_val(alu_result_val),
        .alu_result_rob_pos(alu_result_rob_pos), .alu_result_jump(alu_result_jump),
        .alu_result_pc(alu_result_pc)
    );

    typedef struct {
        logic [31:0]             val;
        logic                    jump;
        logic [31:0]             pc;
        logic [`ROB_POS_WID-1:0] rob;
        int                      age;
    } exp_t;

    exp_t q[$];
    exp_t pending;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_deliv = 0;
    logic dut_vis = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void ref_exec(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                     input logic [31:0] v1, input logic [31:0] v2,
                                     input logic [31:0] imm, input logic [31:0] pc,
                                     output logic [31:0] val, output logic jump,
                                     output logic [31:0] npc);
        logic [31:0] b;
        int          sh;
        logic        taken;
        logic        known;
        val = 0; jump = 0; npc = pc + 4;
        case (op)
            7'h37: val = imm;
            7'h17: val = pc + imm;
            7'h6F: begin val = pc + 4; jump = 1; npc = pc + imm; end
            7'h67: begin val = pc + 4; jump = 1; npc = (v1 + imm) & 32'hFFFF_FFFE; end
            7'h63: begin
                known = 1; taken = 0;
                case (f3)
                    3'd0: taken = (v1 == v2);
                    3'd1: taken = (v1 != v2);
                    3'd4: taken = (int'(v1) < int'(v2));
                    3'd5: taken = (int'(v1) >= int'(v2));
                    3'd6: taken = (longint'(v1) < longint'(v2));
                    3'd7: taken = (longint'(v1) >= longint'(v2));
                    default: known = 0;
                endcase
                if (known) begin
                    jump = taken;
                    npc  = taken ? pc + imm : pc + 4;
                end
            end
            7'h13, 7'h33: begin
                b  = (op == 7'h33) ? v2 : imm;
                sh = int'(b % 32);
                case (f3)
                    3'd0: val = (op == 7'h33 && f7) ? v1 - b : v1 + b;
                    3'd1: val = v1 * (32'd1 << sh);
                    3'd2: val = (int'(v1) < int'(b)) ? 32'd1 : 32'd0;
                    3'd3: val = (longint'(v1) < longint'(b)) ? 32'd1 : 32'd0;
                    3'd4: val = v1 ^ b;
                    3'd5: begin
                        val = v1 / (32'd1 << sh);
                        if (f7 && v1[31] && sh != 0) val = val | ~(32'hFFFF_FFFF >> sh);
                    end
                    3'd6: val = v1 | b;
                    default: val = v1 & b;
                endcase
            end
            default: ;
        endcase
    endfunction

    task automatic set_op(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                          input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] imm,
                          input logic [31:0] pc, input logic [`ROB_POS_WID-1:0] rob);
        alu_en = 1; alu_opcode = op; alu_funct3 = f3; alu_funct7 = f7;
        alu_val1 = v1; alu_val2 = v2; alu_imm = imm; alu_pc = pc; alu_rob_pos = rob;
        ref_exec(op, f3, f7, v1, v2, imm, pc, pending.val, pending.jump, pending.pc);
        pending.rob = rob;
        pending.age = 1;
    endtask

    task automatic set_exp(input logic [31:0] val, input logic jump, input logic [31:0] pc);
        pending.val = val; pending.jump = jump; pending.pc = pc;
    endtask

    // One clock: advance the ROB-side model with the inputs seen at this edge, then compare.
    task automatic cyc();
        logic front_vis;
        logic exp_vis;
        front_vis = (q.size() > 0) && (q[0].age == LAT);
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
        end else if (rdy) begin
            if (dut_vis && !rollback) n_deliv++;
            if (front_vis && !rollback) void'(q.pop_front());
            if (rollback) begin
                q.delete();
            end else begin
                foreach (q[i]) q[i].age++;
                if (alu_en) q.push_back(pending);
            end
        end
        exp_vis = (q.size() > 0) && (q[0].age == LAT);
        check("alu_result", {31'd0, alu_result}, {31'd0, exp_vis});
        if (rst) begin
            check("rst_val", alu_result_val, 32'd0);
            check("rst_pc", alu_result_pc, 32'd0);
            check("rst_jump", {31'd0, alu_result_jump}, 32'd0);
            check("rst_rob", 32'(alu_result_rob_pos), 32'd0);
        end else if (exp_vis) begin
            check("val", alu_result_val, q[0].val);
            check("pc", alu_result_pc, q[0].pc);
            check("jump", {31'd0, alu_result_jump}, {31'd0, q[0].jump});
            check("rob_pos", 32'(alu_result_rob_pos), 32'(q[0].rob));
        end
        dut_vis = alu_result;
    endtask

    task automatic idle(input int n);
        alu_en = 0; rollback = 0;
        for (int i = 0; i < n; i++) cyc();
    endtask

    logic [6:0] opc_tab [0:8];
    int         d0;
    logic [31:0] rv1;

    initial begin
        opc_tab[0] = 7'h37; opc_tab[1] = 7'h17; opc_tab[2] = 7'h6F;
        opc_tab[3] = 7'h67; opc_tab[4] = 7'h63; opc_tab[5] = 7'h13;
        opc_tab[6] = 7'h33; opc_tab[7] = 7'h33; opc_tab[8] = 7'h0B;

        // Reset with rdy low and junk dispatch must still clear everything.
        rst = 1; rdy = 0; rollback = 0;
        set_op(7'h33, 3'd0, 0, 32'd1, 32'd2, 32'd3, 32'h10, 4'd5);
        cyc(); cyc();

        rst = 0; rdy = 1;
        set_op(7'h33, 3'd0, 0, 32'd5, 32'd7, 32'd0, 32'h40, 4'd3);
        set_exp(32'd12, 0, 32'h44);
        cyc();
        set_op(7'h13, 3'd5, 1, 32'h8000_0000, 32'd0, 32'd4, 32'h50, 4'd4);
        set_exp(32'hF800_0000, 0, 32'h54);
        cyc();
        set_op(7'h13, 3'd5, 0, 32'h8000_0000, 32'd0, 32'd4, 32'h54, 4'd5);
        set_exp(32'h0800_0000, 0, 32'h58);
        cyc();
        set_op(7'h63, 3'd4, 0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF0, 32'h100, 4'd6);
        set_exp(32'd0, 1, 32'hF0);
        cyc();
        set_op(7'h63, 3'd6, 0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF0, 32'h100, 4'd7);
        set_exp(32'd0, 0, 32'h104);
        cyc();
        set_op(7'h67, 3'd0, 0, 32'h1001, 32'd0, 32'd4, 32'h200, 4'd8);
        set_exp(32'h204, 1, 32'h1004);
        cyc();
        set_op(7'h0B, 3'd2, 0, 32'h1234, 32'h5678, 32'd8, 32'h300, 4'd9);
        set_exp(32'd0, 0, 32'h304);
        cyc();
        idle(LAT + 2);

        // Rollback on the second of three consecutive dispatches.
        d0 = n_deliv;
        set_op(7'h33, 3'd0, 0, 32'd1, 32'd1, 32'd0, 32'h400, 4'd1);
        cyc();
        set_op(7'h33, 3'd0, 0, 32'd2, 32'd2, 32'd0, 32'h404, 4'd2);
        rollback = 1;
        cyc();
        rollback = 0;
        set_op(7'h33, 3'd0, 0, 32'd3, 32'd3, 32'd0, 32'h408, 4'd3);
        set_exp(32'd6, 0, 32'h40C);
        cyc();
        idle(LAT + 2);
        check("rollback_deliveries", 32'(n_deliv - d0), 32'd1);

        // Three-cycle stall right after a dispatch.
        d0 = n_deliv;
        set_op(7'h13, 3'd4, 0, 32'hF0F0_F0F0, 32'd0, 32'h0FF0_0FF0, 32'h500, 4'd10);
        set_exp(32'hFF00_FF00, 0, 32'h504);
        cyc();
        alu_en = 0; rdy = 0;
        cyc(); cyc(); cyc();
        check("stall_no_delivery", 32'(n_deliv - d0), 32'd0);
        rdy = 1;
        idle(LAT + 3);
        check("stall_deliveries", 32'(n_deliv - d0), 32'd1);

        // Reset and rollback together with an op in flight.
        set_op(7'h6F, 3'd0, 0, 32'd0, 32'd0, 32'h20, 32'h600, 4'd11);
        cyc();
        alu_en = 0; rst = 1; rollback = 1;
        cyc();
        rst = 0; rollback = 0;
        idle(LAT + 1);

        for (int n = 0; n < 3000; n++) begin
            rv1 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : $urandom;
            set_op(opc_tab[$urandom_range(0, 8)], 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   rv1, ($urandom_range(0, 3) == 0) ? rv1 : $urandom, $urandom,
                   $urandom & 32'hFFFF_FFFC, `ROB_POS_WID'($urandom));
            alu_en   = ($urandom_range(0, 4) != 0);
            rdy      = ($urandom_range(0, 4) != 0);
            rollback = ($urandom_range(0, 29) == 0);
            rst      = ($urandom_range(0, 199) == 0);
            cyc();
        end
        rst = 0; rdy = 1;
        idle(LAT + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 rdy  input  1  global enable; low = hold every register, no new capture.
REQ-004 rollback  input  1  flush: discard all in-flight operations.
REQ-005 alu_en  input  1  dispatch valid from reservation station (RS), one op per cycle, no backpressure.
REQ-006 alu_val1, alu_val2, alu_imm, alu_pc  input  32 each  rs1 value, rs2 value, immediate, instruction PC.
REQ-007 alu_opcode  input  `OP_WID  RV32I opcode.
REQ-008 alu_funct3  input  `FUNCT3_WID  funct3.
REQ-009 alu_funct7  input  1  funct7 bit 5 (SUB/SRA/SRAI select).
REQ-010 alu_rob_pos  input  `ROB_POS_WID  destination ROB slot.
REQ-011 alu_result  output  1  broadcast valid (one-cycle pulse per op).
REQ-012 alu_result_val  output  32  rd writeback value.
REQ-013 alu_result_rob_pos  output  `ROB_POS_WID  ROB slot of broadcast.
REQ-014 alu_result_jump  output  1  control transfer taken (JAL, JALR, taken branch).
REQ-015 alu_result_pc  output  32  resolved next PC for control ops; pc+4 for everything else.

Function
REQ-016 Op captured when alu_en=1, rdy=1, rst=0, rollback=0 in that cycle; alu_en ignored otherwise.
REQ-017 Base latency: captured at edge N -> alu_result=1 with outputs valid during cycle N+1 to N+2 edge (one registered stage).
REQ-018 alu_result high for exactly one cycle per captured op; low whenever no op completes.
REQ-019 Back-to-back dispatch every cycle yields back-to-back broadcasts, order preserved.
REQ-020 LUI: val=imm. AUIPC: val=pc+imm.
REQ-021 JAL: val=pc+4, jump=1, pc=pc+imm. JALR: val=pc+4, jump=1, pc=(val1+imm) with bit 0 cleared.
REQ-022 BRANCH: funct3 000 BEQ, 001 BNE, 100 BLT, 101 BGE (signed), 110 BLTU, 111 BGEU (unsigned); jump=cond, pc=cond?pc+imm:pc+4, val=0.
REQ-023 OP-IMM: second operand imm; ADDI/SLTI/SLTIU/XORI/ORI/ANDI; SLLI/SRLI/SRAI use imm[4:0]; funct7 consulted only for funct3=101.
REQ-024 OP: second operand val2; funct7=1 selects SUB (funct3 000) and SRA (101); shift amount val2[4:0].
REQ-025 SLT/SLTI signed compare, SLTU/SLTIU unsigned; result 32'd1 or 32'd0.
REQ-026 All arithmetic modulo 2^32, overflow discarded, no exception.
REQ-027 Unlisted opcode/funct3: broadcast val=0, jump=0, pc=pc+4 (never hang, never drop the ROB slot).
REQ-028 rdy=0: pipeline frozen, alu_result and data outputs hold their current value; on rdy return a held pulse completes without duplication... held alu_result=1 is cleared on the first rdy=1 edge.
REQ-029 rollback=1 (rdy=1): all stage valids cleared at that edge; alu_result=0 next cycle; op dispatched in same cycle dropped.
REQ-030 rollback and rst simultaneous: reset behaviour.

Reset
REQ-031 On rst=1 at an edge: alu_result=0, alu_result_jump=0, alu_result_val=0, alu_result_pc=0, alu_result_rob_pos=0, all stage valids 0; takes effect regardless of rdy.
REQ-032 First op accepted on the first edge after rst deasserts.

Configuration
REQ-033 Macro ALU_PIPE2_EN defined: extra register stage between compute and broadcast (compare/shift in stage 1, branch target/result mux in stage 2); latency 2 cycles, throughput still 1/cycle; rollback/rdy/rst apply to both stages.
REQ-034 ALU_PIPE2_EN undefined: single stage per REQ-017; port list identical in both builds.

Verification
REQ-035 ADD: val1=5, val2=7, funct3=000, funct7=0, rob_pos=3 -> next cycle alu_result=1, val=12, rob_pos=3, jump=0, pc=pc+4.
REQ-036 SRAI: val1=32'h80000000, imm=4, funct3=101, funct7=1 -> val=32'hF8000000; funct7=0 -> val=32'h08000000.
REQ-037 BLT: pc=32'h100, imm=32'hFFFFFFF0, val1=-1, val2=1 -> jump=1, pc=32'hF0; BLTU same operands -> jump=0, pc=32'h104.
REQ-038 JALR: val1=32'h1001, imm=4, pc=32'h200 -> val=32'h204, jump=1, pc=32'h1004.
REQ-039 Dispatch ops on 3 consecutive cycles, rollback on 2nd -> only 3rd op (dispatched after rollback) broadcast; nothing from ops 1-2.
REQ-040 rdy=0 for 3 cycles after dispatch -> no broadcast during stall, exactly one pulse once rdy=1; repeat with ALU_PIPE2_EN for 2-cycle latency.
